fnd_scan_ctrl: RTL
==================

Name: fnd_scan_ctrl

Overview:
- Four-digit multiplexed seven-segment scan driver. Sits directly downstream of the button counter and hex-to-segment stage on the board top level.
- Takes a 16-bit hex value plus per-digit decimal points and time-multiplexes the shared seg/dp lines across the four anodes.
- Replaces the static, switch-driven anode selection, so all four digits show a count at once.
- Drives the board's active-low anode, segment and dp pins directly.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot; 1 kHz per digit at 100 MHz. Legal range is 2 or more.
- BLANK_CYC, 2000: anode-off cycles at the start of each slot. Used only with GHOST_BLANK_EN. Legal range is 0 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- clk  input  1  100 MHz system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  display enable; 0 turns all digits off.
- din  input  16  hex value; din[3:0] is the rightmost digit (digit 0).
- dp_in  input  4  decimal point per digit, active-high; bit i belongs to digit i.
- lz_blank  input  1  1 blanks leading zeros on digits 3..1.
- an  output  4  anodes, active-low, one-hot-low while scanning.
- seg  output  7  segments, active-low; bit0 = a through bit6 = g.
- dp  output  1  decimal point, active-low.
- digit_idx  output  2  digit currently being scanned (internal index).
- scan_tick  output  1  one-cycle pulse at the end of each slot.

Behaviour:
- Reset (rst=0, asynchronous):
  - Internal state: prescaler = 0, idx = 0, shadow value = 0, shadow dp = 0.
  - Outputs: an = 4'hF, seg = 7'h7F, dp = 1, scan_tick = 0, digit_idx = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - scan_tick is combinational and equals (prescaler == SCAN_DIV-1).
  - On the edge where scan_tick=1: prescaler goes to 0 and idx goes to idx+1, wrapping 3 to 0.
  - Prescaler and idx run regardless of en.
- Frame capture:
  - On the tick edge where idx goes from 3 to 0, shadow value <= din and shadow dp <= dp_in.
  - Every digit in a frame therefore shows one coherent value.
  - din changes in mid-frame have no visible effect until the next frame.
- Output stage: an, seg and dp are registered, loaded every cycle from the current idx and shadow registers. They lag idx by exactly 1 clock.
- Anode and segment drive:
  - an = ~(4'b0001 << idx).
  - seg = ~hexpat(shadow nibble idx).
  - dp = ~shadow_dp[idx].
  - hexpat (active-high, bit order g..a):
    - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
    - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Leading-zero blanking (lz_blank=1):
  - Digit k in 3..1 is blanked when every shadow nibble from k up to 3 is zero; a blanked digit drives seg = 7'h7F.
  - Digit 0 is never blanked.
  - The dp of a blanked digit is still driven from shadow dp.
  - lz_blank is sampled live, not shadowed.
- Disable (en=0): an = 4'hF, seg = 7'h7F, dp = 1 from the next clock. Re-enabling resumes at the current idx with no restart.
- Asynchronous reset in mid-slot: all state returns to reset values immediately. After release, scanning starts at digit 0 with the shadow value = 0, so digit 0 shows "0" until the first frame wrap captures din.
- Never more than one anode is low in any cycle.

Optional Feature:
- Macro: GHOST_BLANK_EN.
- Defined:
  - an is forced to 4'hF while prescaler < BLANK_CYC, i.e. for the first BLANK_CYC cycles of each slot.
  - The one-cycle output register lag still applies.
  - seg, dp and scan_tick are unaffected.
  - This suppresses ghosting from segment/anode skew.
- Undefined: no blanking interval. BLANK_CYC is ignored and an is active for the whole slot.

Test Plan:
- Reset, with SCAN_DIV=4 for simulation: hold rst=0 for 3 cycles → an=F, seg=7F, dp=1, digit_idx=0. Release → first scan_tick at cycle 4 after release, digit_idx steps 0,1,2,3,0 every 4 cycles.
- Scan values: en=1, din=16'h12AF, dp_in=4'b0100, lz_blank=0; after one full frame:
  - digit 0: an=E, seg=~71=0E.
  - digit 1: an=D, seg=~77=08.
  - digit 2: an=B, seg=~5B=24, dp=0.
  - digit 3: an=7, seg=~06=79.
  - Each update appears 1 clock after digit_idx changes.
- Frame coherence: change din from 16'h1111 to 16'h2222 while digit_idx=1 → digits 2 and 3 still show "1" for this frame; all digits show "2" from the next frame.
- Leading-zero blanking: din=16'h0050, lz_blank=1 → digit 3 and digit 2 seg=7F, digit 1 seg=~6D=12, digit 0 seg=~3F=40. With din=0000, only digit 0 lit, showing "0".
- Enable and reset in mid-slot: en=0 mid-slot → an=F on the next clock while digit_idx keeps advancing. rst pulsed low mid-slot → an=F asynchronously, restart at digit 0.
- GHOST_BLANK_EN defined, SCAN_DIV=8, BLANK_CYC=2 → in each slot an=F for 2 cycles (offset by 1 clock), then the one-hot-low anode for 6 cycles. Never two anodes low at once.

Source files
------------

// File: rtl/fnd_scan_ctrl_if.sv
// Host-side bundle of the four-digit scan driver: display data in, multiplexed pin drive out.
interface fnd_scan_ctrl_if;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        scan_tick;

  modport master (
    output en, din, dp_in, lz_blank,
    input  an, seg, dp, digit_idx, scan_tick
  );

  modport slave (
    input  en, din, dp_in, lz_blank,
    output an, seg, dp, digit_idx, scan_tick
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan driver with frame-coherent shadow capture.
// Optional GHOST_BLANK_EN: anodes stay off for the first BLANK_CYC cycles of every slot.
module fnd_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2000
) (
  input logic            clk,
  input logic            rst,
  fnd_scan_ctrl_if.slave bus
);

  localparam int unsigned   PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PresMax = PW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || BLANK_CYC >= SCAN_DIV) begin : g_param_check
    $error("fnd_scan_ctrl: SCAN_DIV must be >= 2 and BLANK_CYC < SCAN_DIV");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic [3:0]    nib;
  logic [3:0]    lz_run;
  logic          blank_digit;
  logic          slot_blank;

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  assign tick = (presc_q == PresMax);

  // The shadow only reloads when the scan wraps from digit 3 back to 0, so a frame is coherent.
  always_comb begin
    presc_d     = presc_q + 1'b1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        shadow_d    = bus.din;
        shadow_dp_d = bus.dp_in;
      end
    end
  end

  // lz_run[k]: nibbles k..3 are all zero; digit 0 is never a leading zero.
  always_comb begin
    nib         = shadow_q[{idx_q, 2'b00} +: 4];
    lz_run[3]   = (shadow_q[15:12] == 4'h0);
    lz_run[2]   = lz_run[3] & (shadow_q[11:8] == 4'h0);
    lz_run[1]   = lz_run[2] & (shadow_q[7:4] == 4'h0);
    lz_run[0]   = 1'b0;
    blank_digit = bus.lz_blank & lz_run[idx_q];
  end

`ifdef GHOST_BLANK_EN
  assign slot_blank = (32'(presc_q) < BLANK_CYC);
`else
  assign slot_blank = 1'b0;
`endif

  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (bus.en) begin
      if (!slot_blank) begin
        an_d = ~(4'b0001 << idx_q);
      end
      seg_d = blank_digit ? 7'h7F : ~hexpat(nib);
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      idx_q       <= 2'd0;
      shadow_q    <= 16'h0000;
      shadow_dp_q <= 4'h0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = idx_q;
  assign bus.scan_tick = tick;

endmodule
